toplayici_denetleyici: RTL and testbench
========================================

# toplayici_denetleyici

Shares a single `carry_lookahead_toplayici` instance between two requesters (e.g. ALU and address generation) in the execute stage. Arbitration is round-robin. The block sequences subtraction by inverting operand 2 and forcing carry-in. It also sequences optional 64-bit add/sub as two 32-bit passes with carry propagation. Each request is answered with a one-cycle result pulse tagged with the requester index.

## Interface
Parameters:
- none. Data width is fixed at 32-bit adder, 64-bit ports.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `istek0_gecerli_i` / `istek1_gecerli_i`  in  1  requester 0/1 request valid.
- `istek0_hazir_o` / `istek1_hazir_o`  out  1  requester 0/1 request accepted this cycle.
- `istek0_deger1_i` / `istek1_deger1_i`  in  64  operand 1.
- `istek0_deger2_i` / `istek1_deger2_i`  in  64  operand 2.
- `istek0_cikar_i` / `istek1_cikar_i`  in  1  1 selects `deger1 - deger2`; 0 selects `deger1 + deger2`.
- `istek0_genis_i` / `istek1_genis_i`  in  1  1 selects a 64-bit operation. Only meaningful with `TOPLAYICI_64BIT_EN`.
- `sonuc_gecerli_o`  out  1  result valid, one-cycle pulse.
- `sonuc_hedef_o`  out  1  index of the requester owning the result.
- `sonuc_o`  out  64  result.
- `mesgul_o`  out  1  high whenever the state is not BOSTA.

## Operation
- FSM states: BOSTA, ALT (low pass), UST (high pass), SONUC.
- BOSTA:
  - Handshake is `istekX_gecerli_i && istekX_hazir_o`.
  - `hazir` is combinational. It is high only in BOSTA, and only for the granted requester.
  - On handshake, capture operands, `cikar`, `genis` and requester index. Next state is ALT.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester not served last.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
- ALT:
  - Adder inputs: `deger1[31:0]`, `cikar ? ~deger2[31:0] : deger2[31:0]`, `elde_i = cikar`.
  - Register the 32-bit sum into the low result.
  - Register the low carry-out. The adder has no carry output, so derive it as unsigned: `elde_i=0` gives `c = (toplam < d1)`; `elde_i=1` gives `c = (toplam <= d1)`, where `d1` is the low operand 1.
  - Next state: UST if `genis`, else SONUC.
- UST:
  - Adder inputs: `deger1[63:32]`, `cikar ? ~deger2[63:32] : deger2[63:32]`, `elde_i = registered low carry`.
  - Register the sum into the high result. Next state is SONUC.
- SONUC:
  - Drive `sonuc_gecerli_o=1`, `sonuc_hedef_o`, and `sonuc_o`. Next state is BOSTA.
  - For a 32-bit op, `sonuc_o[63:32] = 0`.
- Requests are not accepted in SONUC. A new acceptance can occur at the earliest in the cycle after the pulse.
- There is no result backpressure. Requesters must consume the pulse.
- Overflow is not reported. Results wrap modulo 2^32 (32-bit op) or 2^64 (64-bit op).

## Timing
- Reset values: state BOSTA, `sonuc_gecerli_o=0`, `sonuc_hedef_o=0`, `sonuc_o=0`, `mesgul_o=0`, both `hazir=0` while reset is asserted, last-served pointer 1.
- Latency, with acceptance at edge N:
  - 32-bit op: `sonuc_gecerli_o` is high during cycle N+2.
  - 64-bit op: `sonuc_gecerli_o` is high during cycle N+3.
- Throughput: one 32-bit op per 3 cycles; one 64-bit op per 4 cycles.
- Operand changes after acceptance have no effect. Operands must be held stable only while `gecerli` is high without `hazir`.
- If reset is asserted mid-operation, the operation is dropped immediately: no result pulse, and the state returns to BOSTA.
- `sonuc_o` holds its last value after the pulse until the next SONUC.

## Configuration
- `TOPLAYICI_64BIT_EN` defined:
  - UST state and the low-carry register are present.
  - `genis_i` selects a 64-bit op.
- Undefined:
  - UST and the carry logic are compiled out, and `istekX_genis_i` is ignored.
  - Every op is 32-bit with latency N+2 and `sonuc_o[63:32] = 0`.

## Test plan
- Requester 0, add 87 + 95, 32-bit, accepted at N → `sonuc_gecerli_o` at N+2, `sonuc_o = 0x0000_0000_0000_00B6`, `sonuc_hedef_o = 0`.
- Requester 1, subtract 87 − 95, 32-bit → `sonuc_o = 0x0000_0000_FFFF_FFF8`, `sonuc_hedef_o = 1`.
- With the macro, 64-bit add `0x0000_0000_FFFF_FFFF + 0x1` → result at N+3, `sonuc_o = 0x0000_0001_0000_0000`.
- With the macro, 64-bit subtract `0x0000_0001_0000_0000 − 0x1` → `sonuc_o = 0x0000_0000_FFFF_FFFF`.
- Both requesters valid from reset with add 1 + 2 and add 3 + 4 → requester 0 is served first (result 3, hedef 0), then requester 1 (result 7, hedef 1). A back-to-back repeat of both alternates the order.
- Assert `rst_i` low in the cycle after acceptance of a 64-bit op → no `sonuc_gecerli_o` pulse, `sonuc_o = 0`, `mesgul_o = 0`. The next request completes normally.

Source files
------------

// File: rtl/toplayici_denetleyici.sv
// Two requesters share one 32-bit carry-lookahead adder under round-robin arbitration.
// Define TOPLAYICI_64BIT_EN for two-pass 64-bit add/sub (genis); without it every op is 32-bit.

module carry_lookahead_toplayici (
  input  logic [31:0] deger1_i,
  input  logic [31:0] deger2_i,
  input  logic        elde_i,
  output logic [31:0] toplam_o
);

  logic [31:0] uret;
  logic [31:0] yay;
  logic [7:0]  grup_uret;
  logic [7:0]  grup_yay;
  logic [7:0]  grup_elde;
  logic        unused_son_grup;

  assign uret = deger1_i & deger2_i;
  assign yay  = deger1_i ^ deger2_i;

  // Lookahead inside each 4-bit group; group carries chain on the group generate/propagate terms.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_grup
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] c;

      assign g    = uret[4*gi +: 4];
      assign p    = yay[4*gi +: 4];
      assign c[0] = grup_elde[gi];
      assign c[1] = g[0] | (p[0] & grup_elde[gi]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & grup_elde[gi]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & grup_elde[gi]);

      assign grup_uret[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                           | (p[3] & p[2] & p[1] & g[0]);
      assign grup_yay[gi]  = &p;

      assign toplam_o[4*gi +: 4] = p ^ c;
    end
  endgenerate

  always_comb begin
    grup_elde[0] = elde_i;
    for (int k = 1; k < 8; k++) begin
      grup_elde[k] = grup_uret[k-1] | (grup_yay[k-1] & grup_elde[k-1]);
    end
  end

  // The adder exposes no carry-out, so the top group's terms go nowhere.
  assign unused_son_grup = grup_uret[7] | grup_yay[7];

endmodule

module toplayici_denetleyici (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istek0_gecerli_i,
  output logic        istek0_hazir_o,
  input  logic [63:0] istek0_deger1_i,
  input  logic [63:0] istek0_deger2_i,
  input  logic        istek0_cikar_i,
  input  logic        istek0_genis_i,
  input  logic        istek1_gecerli_i,
  output logic        istek1_hazir_o,
  input  logic [63:0] istek1_deger1_i,
  input  logic [63:0] istek1_deger2_i,
  input  logic        istek1_cikar_i,
  input  logic        istek1_genis_i,
  output logic        sonuc_gecerli_o,
  output logic        sonuc_hedef_o,
  output logic [63:0] sonuc_o,
  output logic        mesgul_o
);

`ifdef TOPLAYICI_64BIT_EN
  localparam int OW = 64;
`else
  localparam int OW = 32;
`endif

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] ALT   = 2'd1;
`ifdef TOPLAYICI_64BIT_EN
  localparam logic [1:0] UST   = 2'd2;
`endif
  localparam logic [1:0] SONUC = 2'd3;

  logic [1:0]    durum_q, durum_d;
  logic          son_hizmet_q, son_hizmet_d;
  logic          hedef_q, hedef_d;
  logic          cikar_q, cikar_d;
  logic [OW-1:0] deger1_q, deger1_d;
  logic [OW-1:0] deger2_q, deger2_d;
  logic [63:0]   sonuc_q, sonuc_d;
  logic          sonuc_gecerli_q, sonuc_gecerli_d;
  logic          sonuc_hedef_q, sonuc_hedef_d;
`ifdef TOPLAYICI_64BIT_EN
  logic          genis_q, genis_d;
  logic [31:0]   alt_q, alt_d;
  logic          elde_q, elde_d;
  logic          alt_elde;
`else
  logic          unused_girisler;
`endif

  logic          bosta;
  logic          izin0;
  logic          izin1;
  logic          kabul;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic          add_ci;
  logic [31:0]   toplam;

  carry_lookahead_toplayici u_toplayici (
    .deger1_i (add_a),
    .deger2_i (add_b),
    .elde_i   (add_ci),
    .toplam_o (toplam)
  );

  // Gated by rst_i so neither requester sees an acceptance while reset is held.
  assign bosta = rst_i && (durum_q == BOSTA);
  assign izin0 = istek0_gecerli_i && (!istek1_gecerli_i || son_hizmet_q);
  assign izin1 = istek1_gecerli_i && (!istek0_gecerli_i || !son_hizmet_q);

  assign istek0_hazir_o = bosta && izin0;
  assign istek1_hazir_o = bosta && izin1;
  assign kabul          = istek0_hazir_o || istek1_hazir_o;

  always_comb begin
    add_a  = deger1_q[31:0];
    add_b  = cikar_q ? ~deger2_q[31:0] : deger2_q[31:0];
    add_ci = cikar_q;
`ifdef TOPLAYICI_64BIT_EN
    if (durum_q == UST) begin
      add_a  = deger1_q[63:32];
      add_b  = cikar_q ? ~deger2_q[63:32] : deger2_q[63:32];
      add_ci = elde_q;
    end
`endif
  end

`ifdef TOPLAYICI_64BIT_EN
  // Unsigned wrap test recovers the low-pass carry; with carry-in set, equality also means carry.
  assign alt_elde = cikar_q ? (toplam <= deger1_q[31:0]) : (toplam < deger1_q[31:0]);
`else
  assign unused_girisler = ^{istek0_genis_i, istek1_genis_i,
                             istek0_deger1_i[63:32], istek0_deger2_i[63:32],
                             istek1_deger1_i[63:32], istek1_deger2_i[63:32]};
`endif

  always_comb begin
    durum_d         = durum_q;
    son_hizmet_d    = son_hizmet_q;
    hedef_d         = hedef_q;
    cikar_d         = cikar_q;
    deger1_d        = deger1_q;
    deger2_d        = deger2_q;
    sonuc_d         = sonuc_q;
    sonuc_gecerli_d = 1'b0;
    sonuc_hedef_d   = sonuc_hedef_q;
`ifdef TOPLAYICI_64BIT_EN
    genis_d         = genis_q;
    alt_d           = alt_q;
    elde_d          = elde_q;
`endif

    case (durum_q)
      BOSTA: begin
        if (kabul) begin
          hedef_d      = istek1_hazir_o;
          son_hizmet_d = istek1_hazir_o;
          cikar_d      = istek1_hazir_o ? istek1_cikar_i : istek0_cikar_i;
          deger1_d     = istek1_hazir_o ? istek1_deger1_i[OW-1:0] : istek0_deger1_i[OW-1:0];
          deger2_d     = istek1_hazir_o ? istek1_deger2_i[OW-1:0] : istek0_deger2_i[OW-1:0];
`ifdef TOPLAYICI_64BIT_EN
          genis_d      = istek1_hazir_o ? istek1_genis_i : istek0_genis_i;
`endif
          durum_d      = ALT;
        end
      end

      ALT: begin
`ifdef TOPLAYICI_64BIT_EN
        alt_d  = toplam;
        elde_d = alt_elde;
        if (genis_q) begin
          durum_d = UST;
        end else begin
          sonuc_d         = {32'h0, toplam};
          sonuc_gecerli_d = 1'b1;
          sonuc_hedef_d   = hedef_q;
          durum_d         = SONUC;
        end
`else
        sonuc_d         = {32'h0, toplam};
        sonuc_gecerli_d = 1'b1;
        sonuc_hedef_d   = hedef_q;
        durum_d         = SONUC;
`endif
      end

`ifdef TOPLAYICI_64BIT_EN
      UST: begin
        sonuc_d         = {toplam, alt_q};
        sonuc_gecerli_d = 1'b1;
        sonuc_hedef_d   = hedef_q;
        durum_d         = SONUC;
      end
`endif

      SONUC: begin
        durum_d = BOSTA;
      end

      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q         <= BOSTA;
      son_hizmet_q    <= 1'b1;
      hedef_q         <= 1'b0;
      cikar_q         <= 1'b0;
      deger1_q        <= '0;
      deger2_q        <= '0;
      sonuc_q         <= '0;
      sonuc_gecerli_q <= 1'b0;
      sonuc_hedef_q   <= 1'b0;
`ifdef TOPLAYICI_64BIT_EN
      genis_q         <= 1'b0;
      alt_q           <= '0;
      elde_q          <= 1'b0;
`endif
    end else begin
      durum_q         <= durum_d;
      son_hizmet_q    <= son_hizmet_d;
      hedef_q         <= hedef_d;
      cikar_q         <= cikar_d;
      deger1_q        <= deger1_d;
      deger2_q        <= deger2_d;
      sonuc_q         <= sonuc_d;
      sonuc_gecerli_q <= sonuc_gecerli_d;
      sonuc_hedef_q   <= sonuc_hedef_d;
`ifdef TOPLAYICI_64BIT_EN
      genis_q         <= genis_d;
      alt_q           <= alt_d;
      elde_q          <= elde_d;
`endif
    end
  end

  assign sonuc_gecerli_o = sonuc_gecerli_q;
  assign sonuc_hedef_o   = sonuc_hedef_q;
  assign sonuc_o         = sonuc_q;
  assign mesgul_o        = (durum_q != BOSTA);

endmodule

// File: tb/tb_toplayici_denetleyici.sv
// Scoreboard bench for toplayici_denetleyici: random requests against an arithmetic reference model.
module tb_toplayici_denetleyici;

`ifdef TOPLAYICI_64BIT_EN
  localparam bit GENIS_VAR = 1'b1;
`else
  localparam bit GENIS_VAR = 1'b0;
`endif

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic        req_v   [0:1];
  logic [63:0] req_d1  [0:1];
  logic [63:0] req_d2  [0:1];
  logic        req_c   [0:1];
  logic        req_g   [0:1];
  logic [63:0] req_exp [0:1];

  logic        istek0_gecerli_i, istek1_gecerli_i;
  logic        istek0_hazir_o, istek1_hazir_o;
  logic [63:0] istek0_deger1_i, istek0_deger2_i, istek1_deger1_i, istek1_deger2_i;
  logic        istek0_cikar_i, istek1_cikar_i, istek0_genis_i, istek1_genis_i;
  logic        sonuc_gecerli_o, sonuc_hedef_o, mesgul_o;
  logic [63:0] sonuc_o;

  assign istek0_gecerli_i = req_v[0];
  assign istek1_gecerli_i = req_v[1];
  assign istek0_deger1_i  = req_d1[0];
  assign istek1_deger1_i  = req_d1[1];
  assign istek0_deger2_i  = req_d2[0];
  assign istek1_deger2_i  = req_d2[1];
  assign istek0_cikar_i   = req_c[0];
  assign istek1_cikar_i   = req_c[1];
  assign istek0_genis_i   = req_g[0];
  assign istek1_genis_i   = req_g[1];

  toplayici_denetleyici dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .istek0_gecerli_i (istek0_gecerli_i),
    .istek0_hazir_o   (istek0_hazir_o),
    .istek0_deger1_i  (istek0_deger1_i),
    .istek0_deger2_i  (istek0_deger2_i),
    .istek0_cikar_i   (istek0_cikar_i),
    .istek0_genis_i   (istek0_genis_i),
    .istek1_gecerli_i (istek1_gecerli_i),
    .istek1_hazir_o   (istek1_hazir_o),
    .istek1_deger1_i  (istek1_deger1_i),
    .istek1_deger2_i  (istek1_deger2_i),
    .istek1_cikar_i   (istek1_cikar_i),
    .istek1_genis_i   (istek1_genis_i),
    .sonuc_gecerli_o  (sonuc_gecerli_o),
    .sonuc_hedef_o    (sonuc_hedef_o),
    .sonuc_o          (sonuc_o),
    .mesgul_o         (mesgul_o)
  );

  typedef struct {
    logic        hedef;
    logic [63:0] deger;
    int          kenar;
  } beklenen_t;

  beklenen_t sb[$];
  beklenen_t mon_b;
  int        cyc = 0;
  int        serbest = 0;
  int        n_tests = 0;
  int        n_fail = 0;
  logic      son = 1'b1;
  int        k;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    n_tests++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: gercek=0x%0h beklenen=0x%0h t=%0t", ad, gercek, beklenen, $time);
    end
  endtask

  // Reference arithmetic: plain two's-complement add/sub, truncated to 32 bits unless a wide op.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic c, input logic g);
    logic [63:0] r;
    r = c ? (a - b) : (a + b);
    if (!(g && GENIS_VAR)) r = {32'h0, r[31:0]};
    return r;
  endfunction

  function automatic logic [63:0] rastgele();
    case ($urandom_range(0, 4))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h0000_0000_FFFF_FFFF;
      3:       return 64'h0000_0001_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (sonuc_gecerli_o) begin
      if (sb.size() == 0) begin
        chk("beklenmeyen_sonuc", 64'(sonuc_gecerli_o), 64'd0);
      end else begin
        mon_b = sb.pop_front();
        $display("[TB] sonuc hedef=%0d deger=0x%h dongu=%0d", sonuc_hedef_o, sonuc_o, cyc);
        chk("sonuc_hedef", 64'(sonuc_hedef_o), 64'(mon_b.hedef));
        chk("sonuc_deger", sonuc_o, mon_b.deger);
        chk("sonuc_gecikme", 64'(cyc), 64'(mon_b.kenar));
      end
    end
  end

  task automatic yukle(input int i, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic g);
    req_d1[i]  = a;
    req_d2[i]  = b;
    req_c[i]   = c;
    req_g[i]   = g;
    req_exp[i] = model(a, b, c, g);
    req_v[i]   = 1'b1;
  endtask

  // One cycle, called at a falling edge: predict grants, check them, log acceptances.
  task automatic adim(output int kabul);
    logic      bos, g, e0, e1;
    beklenen_t b;
    #1;
    bos = (cyc + 1 >= serbest);
    chk("mesgul", 64'(mesgul_o), 64'(!bos));
    if (req_v[0] && req_v[1]) g = ~son;
    else                      g = !req_v[0];
    e0 = bos && req_v[0] && !g;
    e1 = bos && req_v[1] && g;
    chk("hazir0", 64'(istek0_hazir_o), 64'(e0));
    chk("hazir1", 64'(istek1_hazir_o), 64'(e1));
    kabul = -1;
    if (e0 || e1) begin
      b.hedef = g;
      b.deger = req_exp[g];
      b.kenar = cyc + 1 + ((req_g[g] && GENIS_VAR) ? 2 : 1);
      sb.push_back(b);
      serbest = b.kenar + 2;
      son     = g;
      kabul   = int'(g);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    if (kabul >= 0) begin
      req_v[kabul]  = 1'b0;
      req_d1[kabul] = ~req_d1[kabul];
      req_d2[kabul] = {$urandom, $urandom};
    end
  endtask

  task automatic bekle(input int i);
    int kk;
    for (int n = 0; n < 40 && req_v[i]; n++) adim(kk);
    chk("kabul_zaman_asimi", 64'(req_v[i]), 64'd0);
  endtask

  task automatic bosalt();
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk_i);
    chk("kuyruk_bos", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: gercek=zaman_asimi beklenen=bitis");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    yukle(0, 64'd1, 64'd2, 1'b0, 1'b0);
    req_exp[0] = 64'd3;
    yukle(1, 64'd3, 64'd4, 1'b0, 1'b0);
    req_exp[1] = 64'd7;
    repeat (3) @(negedge clk_i);
    #1;
    chk("reset_hazir0", 64'(istek0_hazir_o), 64'd0);
    chk("reset_hazir1", 64'(istek1_hazir_o), 64'd0);
    chk("reset_gecerli", 64'(sonuc_gecerli_o), 64'd0);
    chk("reset_hedef", 64'(sonuc_hedef_o), 64'd0);
    chk("reset_sonuc", sonuc_o, 64'd0);
    chk("reset_mesgul", 64'(mesgul_o), 64'd0);
    @(negedge clk_i);
    rst_i   = 1'b1;
    serbest = 0;
    son     = 1'b1;

    // Tie from reset: requester 0 first, then 1; then both again back to back.
    bekle(0);
    bekle(1);
    yukle(0, 64'd1, 64'd2, 1'b0, 1'b0);
    yukle(1, 64'd3, 64'd4, 1'b0, 1'b0);
    bekle(0);
    bekle(1);

    yukle(0, 64'd87, 64'd95, 1'b0, 1'b0);
    req_exp[0] = 64'h0000_0000_0000_00B6;
    bekle(0);
    yukle(1, 64'd87, 64'd95, 1'b1, 1'b0);
    req_exp[1] = 64'h0000_0000_FFFF_FFF8;
    bekle(1);
    yukle(0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    req_exp[0] = GENIS_VAR ? 64'h0000_0001_0000_0000 : 64'h0;
    bekle(0);
    yukle(1, 64'h0000_0001_0000_0000, 64'h1, 1'b1, 1'b1);
    req_exp[1] = 64'h0000_0000_FFFF_FFFF;
    bekle(1);
    bosalt();

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i] && ($urandom_range(0, 1) == 1))
          yukle(i, rastgele(), rastgele(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      adim(k);
    end
    for (int i = 0; i < 2; i++) if (req_v[i]) bekle(i);
    bosalt();

    // Reset one cycle after accepting a wide op: the op must vanish without a pulse.
    yukle(0, rastgele(), rastgele(), 1'($urandom_range(0, 1)), 1'b1);
    k = -1;
    for (int n = 0; n < 40 && k != 0; n++) adim(k);
    chk("reset_oncesi_kabul", 64'(k), 64'd0);
    rst_i = 1'b0;
    yukle(1, 64'd10, 64'd20, 1'b0, 1'b0);
    #1;
    chk("orta_reset_mesgul", 64'(mesgul_o), 64'd0);
    chk("orta_reset_sonuc", sonuc_o, 64'd0);
    chk("orta_reset_gecerli", 64'(sonuc_gecerli_o), 64'd0);
    chk("orta_reset_hazir1", 64'(istek1_hazir_o), 64'd0);
    sb.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i   = 1'b1;
    serbest = 0;
    son     = 1'b1;
    bekle(1);
    bosalt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
